// File: rtl/aes_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_block_sequencer_if
//   Bundles every signal between the block sequencer and its three peers:
//     buffer side : buf_empty, buf_data (show-ahead), buf_read_en
//     AES side    : aes_key, aes_pt, aes_start, aes_done, aes_ct
//     UART side   : tx_data, tx_start, tx_busy
//     status      : key_valid, busy, timeout_err, trigger
//   master modport = the sequencer, slave modport = the surrounding blocks.
// ---------------------------------------------------------------------------
interface aes_block_sequencer_if;
  logic         buf_empty;
  logic [127:0] buf_data;
  logic         buf_read_en;
  logic [127:0] aes_key;
  logic [127:0] aes_pt;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_ct;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic         key_valid;
  logic         busy;
  logic         timeout_err;
  logic         trigger;

  modport master (
    input  buf_empty, buf_data, aes_done, aes_ct, tx_busy,
    output buf_read_en, aes_key, aes_pt, aes_start, tx_data, tx_start,
           key_valid, busy, timeout_err, trigger
  );

  modport slave (
    output buf_empty, buf_data, aes_done, aes_ct, tx_busy,
    input  buf_read_en, aes_key, aes_pt, aes_start, tx_data, tx_start,
           key_valid, busy, timeout_err, trigger
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// ---------------------------------------------------------------------------
// aes_block_sequencer
//   Pulls 128-bit blocks from the UART receive buffer. The first block after
//   reset becomes the AES key; each later block is a plaintext that launches
//   one encryption, whose ciphertext is streamed to the UART MSB byte first.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low; clears all state and outputs
//     bus    - aes_block_sequencer_if.master (buffer / AES / UART / status)
//
//   Parameters:
//     TIMEOUT   - cycles allowed for aes_done (2..65535)
//     READ_HOLD - cycles after buf_read_en before looking at buf_empty (>=2)
//
//   Build option:
//     SCA_TRIGGER_EN - when defined, trigger brackets the AES active window
//                      (aes_start cycle through the aes_done/timeout cycle).
//                      When undefined, trigger is tied to 0.
// ---------------------------------------------------------------------------
module aes_block_sequencer #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned READ_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_block_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, RELEASE, START, WAIT_AES, TX_LOAD, TX_WAIT
  } state_e;

  localparam logic [15:0] HOLD_LAST    = 16'(READ_HOLD - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;          // read-hold / AES-timeout / tx-latency counter
  logic          empty_seen_q, empty_seen_d;
  logic          cap_key_q, cap_key_d;  // last captured block was the key
  logic [3:0]    idx_q, idx_d;
  logic [127:0]  sh_q, sh_d;            // ciphertext shift register
  logic          buf_read_en_q, buf_read_en_d;
  logic          aes_start_q, aes_start_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  pt_q, pt_d;
  logic          key_valid_q, key_valid_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    empty_seen_d  = 1'b0;
    cap_key_d     = cap_key_q;
    idx_d         = idx_q;
    sh_d          = sh_q;
    buf_read_en_d = 1'b0;
    aes_start_d   = 1'b0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    key_d         = key_q;
    pt_d          = pt_q;
    key_valid_d   = key_valid_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        // Empty flag and data settle one cycle apart: require two
        // consecutive non-empty samples before reading.
        empty_seen_d = !bus.buf_empty;
        if (empty_seen_q && !bus.buf_empty) begin
          empty_seen_d  = 1'b0;
          buf_read_en_d = 1'b1;
          state_d       = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!key_valid_q) begin
          key_d       = bus.buf_data;
          key_valid_d = 1'b1;
          cap_key_d   = 1'b1;
        end else begin
          pt_d      = bus.buf_data;
          cap_key_d = 1'b0;
        end
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (cnt_q == HOLD_LAST) begin
          if (cap_key_q) begin
            state_d = IDLE;
          end else begin
            aes_start_d = 1'b1;
            state_d     = START;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_AES;
      end
      WAIT_AES: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.aes_done) begin
          idx_d = '0;
          // Issue byte 0 straight from aes_ct when the UART is free so the
          // first tx_start lands the cycle after aes_done.
          if (!bus.tx_busy) begin
            tx_data_d  = bus.aes_ct[127:120];
            tx_start_d = 1'b1;
            sh_d       = {bus.aes_ct[119:0], 8'h00};
            cnt_d      = '0;
            state_d    = TX_WAIT;
          end else begin
            sh_d    = bus.aes_ct;
            state_d = TX_LOAD;
          end
        end else if (cnt_d == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      TX_LOAD: begin
        if (!bus.tx_busy) begin
          tx_data_d  = sh_q[127:120];
          tx_start_d = 1'b1;
          sh_d       = {sh_q[119:0], 8'h00};
          cnt_d      = '0;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // The transmitter raises tx_busy one cycle after tx_start.
        if (cnt_q == 16'd0) begin
          cnt_d = 16'd1;
        end else if (!bus.tx_busy) begin
          if (idx_q == 4'd15) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  // NOTE: the 128-bit data registers are reset too, so a reset visibly
  // clears the key, plaintext and pending ciphertext.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      empty_seen_q  <= 1'b0;
      cap_key_q     <= 1'b0;
      idx_q         <= '0;
      sh_q          <= '0;
      buf_read_en_q <= 1'b0;
      aes_start_q   <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      key_q         <= '0;
      pt_q          <= '0;
      key_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      empty_seen_q  <= empty_seen_d;
      cap_key_q     <= cap_key_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      buf_read_en_q <= buf_read_en_d;
      aes_start_q   <= aes_start_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      key_q         <= key_d;
      pt_q          <= pt_d;
      key_valid_q   <= key_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.buf_read_en = buf_read_en_q;
  assign bus.aes_start   = aes_start_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.aes_key     = key_q;
  assign bus.aes_pt      = pt_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

`ifdef SCA_TRIGGER_EN
  logic trigger_q, trigger_d;

  // High from the aes_start cycle until WAIT_AES is left (done or timeout).
  always_comb begin
    trigger_d = trigger_q;
    if (aes_start_d) begin
      trigger_d = 1'b1;
    end else if (state_q == WAIT_AES && state_d != WAIT_AES) begin
      trigger_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trigger_q <= 1'b0;
    else        trigger_q <= trigger_d;
  end

  assign bus.trigger = trigger_q;
`else
  assign bus.trigger = 1'b0;
`endif

endmodule

// File: tb/tb_aes_block_sequencer.sv
module tb_aes_block_sequencer;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int READ_HOLD = 4;
  localparam int TIMEOUT   = 16;
`ifdef SCA_TRIGGER_EN
  localparam int TRIG_EXP = 11;
`else
  localparam int TRIG_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_block_sequencer_if bus ();

  aes_block_sequencer #(.TIMEOUT(TIMEOUT), .READ_HOLD(READ_HOLD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] buf_q[$];
  logic [7:0]   exp_q[$];
  int  tx_hold = 2;
  bit  aes_en  = 1'b1;

  // Event records, indexed by cyc (number of rising edges so far).
  int cyc = 0;
  int n_rd = 0, n_start = 0, n_tx = 0, trig_cnt = 0;
  int last_rd_cyc = 0, last_start_cyc = 0, last_done_cyc = 0, last_tx_cyc = -1000;
  int empty_fall_cyc = 0, busy_fall_cyc = 0, terr_cyc = 0;
  int first_tx_gap = -1, min_gap = 1000;
  bit done_pending = 1'b0;

  function automatic logic [127:0] ct_of(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_1234_a5a5_4321_0f0f_f0f0_3c3c_c3c3;
  endfunction

  task automatic push_exp(input logic [127:0] ct);
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
  endtask

  always @(posedge clk) cyc++;

  // Buffer model: show-ahead FIFO, pops on buf_read_en.
  initial begin
    logic rd;
    bus.buf_empty = 1'b1;
    bus.buf_data  = '0;
    forever begin
      @(posedge clk);
      rd = bus.buf_read_en;
      #1;
      if (rd && buf_q.size() > 0) void'(buf_q.pop_front());
      bus.buf_empty = (buf_q.size() == 0);
      bus.buf_data  = (buf_q.size() > 0) ? buf_q[0] : '0;
    end
  end

  // AES model: aes_done 10 cycles after aes_start when enabled.
  initial begin
    logic st;
    int cd;
    logic [127:0] ct;
    cd = 0;
    ct = '0;
    bus.aes_done = 1'b0;
    bus.aes_ct   = '0;
    forever begin
      @(posedge clk);
      st = bus.aes_start;
      #1;
      bus.aes_done = 1'b0;
      if (st && aes_en) begin
        cd = 9;
        ct = ct_of(bus.aes_key, bus.aes_pt);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.aes_done = 1'b1;
          bus.aes_ct   = ct;
        end
      end
    end
  end

  // UART model: busy for tx_hold cycles starting the cycle after tx_start.
  initial begin
    logic ts;
    int bc;
    bc = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      ts = bus.tx_start;
      #1;
      if (ts) bc = tx_hold;
      else if (bc > 0) bc--;
      bus.tx_busy = (bc != 0);
    end
  end

  // Monitor and scoreboard.
  initial begin
    logic empty_prev, busy_prev, terr_prev;
    logic [7:0] exp_b;
    empty_prev = 1'b1;
    busy_prev  = 1'b0;
    terr_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (empty_prev && !bus.buf_empty) empty_fall_cyc = cyc;
      empty_prev = bus.buf_empty;
      if (bus.buf_read_en) begin n_rd++; last_rd_cyc = cyc; end
      if (bus.aes_start)   begin n_start++; last_start_cyc = cyc; end
      if (bus.aes_done)    begin last_done_cyc = cyc; done_pending = 1'b1; end
      if (bus.trigger) trig_cnt++;
      if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
      busy_prev = bus.busy;
      if (!terr_prev && bus.timeout_err) terr_cyc = cyc;
      terr_prev = bus.timeout_err;
      if (bus.tx_start) begin
        checks++;
        if (bus.tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL tx_issue_busy: tx_busy=%b at tx_start, required 0", bus.tx_busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte_unexpected: got %02h, required no byte", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_byte: got %02h, required %02h", bus.tx_data, exp_b);
          end
        end
        if (done_pending) begin first_tx_gap = cyc - last_done_cyc; done_pending = 1'b0; end
        if (cyc - last_tx_cyc < min_gap) min_gap = cyc - last_tx_cyc;
        last_tx_cyc = cyc;
        n_tx++;
      end
    end
  end

  task automatic wait_drained(input string name, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!(exp_q.size() == 0 && !bus.busy && buf_q.size() == 0) && k < budget);
    checks++;
    if (!(exp_q.size() == 0 && !bus.busy && buf_q.size() == 0)) begin
      errors++;
      $display("FAIL %s_drain: still busy=%b pending_bytes=%0d after %0d cycles, required idle",
               name, bus.busy, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.buf_read_en, bus.aes_key, bus.aes_pt, bus.aes_start, bus.tx_data, bus.tx_start,
         bus.key_valid, bus.busy, bus.timeout_err, bus.trigger} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero (key=%h busy=%b), required all 0",
               bus.aes_key, bus.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_key_only();
    int s0 = n_start, t0 = n_tx;
    buf_q.push_back(FIPS_KEY);
    wait_drained("key_only", 100);
    checks++;
    if (last_rd_cyc - empty_fall_cyc !== 2) begin
      errors++;
      $display("FAIL key_rd_latency: %0d cycles, required 2", last_rd_cyc - empty_fall_cyc);
    end
    checks++;
    if (bus.key_valid !== 1'b1) begin
      errors++;
      $display("FAIL key_valid: got %b, required 1", bus.key_valid);
    end
    checks++;
    if (bus.aes_key !== FIPS_KEY) begin
      errors++;
      $display("FAIL key_value: got %h, required %h", bus.aes_key, FIPS_KEY);
    end
    checks++;
    if (busy_fall_cyc - last_rd_cyc !== READ_HOLD + 1) begin
      errors++;
      $display("FAIL key_busy_len: %0d, required %0d", busy_fall_cyc - last_rd_cyc, READ_HOLD + 1);
    end
    checks++;
    if (n_start - s0 !== 0 || n_tx - t0 !== 0) begin
      errors++;
      $display("FAIL key_no_activity: starts=%0d tx=%0d, required 0 and 0", n_start - s0, n_tx - t0);
    end
  endtask

  task automatic test_fips_block();
    int s0 = n_start, t0 = n_tx, tr0 = trig_cnt;
    min_gap = 1000;
    buf_q.push_back(FIPS_PT);
    push_exp(FIPS_CT);
    wait_drained("fips", 400);
    checks++;
    if (bus.aes_pt !== FIPS_PT || bus.aes_key !== FIPS_KEY) begin
      errors++;
      $display("FAIL fips_held: key=%h pt=%h, required %h %h", bus.aes_key, bus.aes_pt, FIPS_KEY, FIPS_PT);
    end
    checks++;
    if (n_start - s0 !== 1) begin
      errors++;
      $display("FAIL fips_starts: %0d, required 1", n_start - s0);
    end
    checks++;
    if (last_start_cyc - last_rd_cyc !== READ_HOLD + 1) begin
      errors++;
      $display("FAIL fips_start_latency: %0d, required %0d", last_start_cyc - last_rd_cyc, READ_HOLD + 1);
    end
    checks++;
    if (first_tx_gap !== 1) begin
      errors++;
      $display("FAIL fips_first_tx: %0d cycles after done, required 1", first_tx_gap);
    end
    checks++;
    if (n_tx - t0 !== 16) begin
      errors++;
      $display("FAIL fips_tx_count: %0d, required 16", n_tx - t0);
    end
    checks++;
    if (min_gap < 3) begin
      errors++;
      $display("FAIL fips_tx_spacing: min gap %0d, required >= 3", min_gap);
    end
    checks++;
    if (trig_cnt - tr0 !== TRIG_EXP) begin
      errors++;
      $display("FAIL fips_trigger: high %0d cycles, required %0d", trig_cnt - tr0, TRIG_EXP);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] pt2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    logic [127:0] pt3 = 128'h0badc0de_11112222_33334444_55556666;
    int t0 = n_tx, s0, k;
    aes_en = 1'b0;
    buf_q.push_back(pt2);
    k = 0;
    while (!bus.timeout_err && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: got %b, required 1", bus.timeout_err);
    end
    checks++;
    if (terr_cyc - last_start_cyc !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: %0d, required %0d", terr_cyc - last_start_cyc, TIMEOUT);
    end
    checks++;
    if (bus.trigger !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: trigger=%b busy=%b, required 0 0", bus.trigger, bus.busy);
    end
    aes_en = 1'b1;
    s0 = n_start;
    buf_q.push_back(pt3);
    push_exp(ct_of(FIPS_KEY, pt3));
    wait_drained("after_timeout", 400);
    checks++;
    if (n_start - s0 !== 1 || n_tx - t0 !== 16) begin
      errors++;
      $display("FAIL timeout_recover: starts=%0d tx=%0d, required 1 and 16", n_start - s0, n_tx - t0);
    end
  endtask

  task automatic test_slow_tx();
    logic [127:0] pt4 = 128'h11223344_55667788_99aabbcc_ddeeff00;
    logic [127:0] pt5 = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
    int t0 = n_tx, r0 = n_rd, k, t16;
    tx_hold = 50;
    min_gap = 1000;
    buf_q.push_back(pt4);
    buf_q.push_back(pt5);
    push_exp(ct_of(FIPS_KEY, pt4));
    push_exp(ct_of(FIPS_KEY, pt5));
    k = 0;
    while (n_tx - t0 < 16 && k < 1500) begin @(negedge clk); k++; end
    t16 = last_tx_cyc;
    k = 0;
    while (n_rd - r0 < 2 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (n_rd - r0 !== 2 || n_tx - t0 !== 16) begin
      errors++;
      $display("FAIL slow_second_read: reads=%0d tx=%0d at second read, required 2 and 16", n_rd - r0, n_tx - t0);
    end
    checks++;
    if (last_rd_cyc - t16 <= 50) begin
      errors++;
      $display("FAIL slow_read_order: read %0d cycles after byte 15, required > 50", last_rd_cyc - t16);
    end
    wait_drained("slow", 1500);
    checks++;
    if (n_tx - t0 !== 32 || min_gap < 3) begin
      errors++;
      $display("FAIL slow_tx_count: tx=%0d min_gap=%0d, required 32 and >= 3", n_tx - t0, min_gap);
    end
    tx_hold = 2;
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt6 = 128'h00000000_11111111_22222222_33333333;
    logic [127:0] key2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    int t0 = n_tx, s0, k;
    buf_q.push_back(pt6);
    push_exp(ct_of(FIPS_KEY, pt6));
    k = 0;
    while (n_tx - t0 < 5 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (n_tx - t0 !== 5) begin
      errors++;
      $display("FAIL mid_progress: tx=%0d, required 5", n_tx - t0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.buf_read_en, bus.aes_key, bus.aes_pt, bus.aes_start, bus.tx_data, bus.tx_start,
         bus.key_valid, bus.busy, bus.timeout_err, bus.trigger} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: key_valid=%b busy=%b terr=%b, required all outputs 0",
               bus.key_valid, bus.busy, bus.timeout_err);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.key_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_key_cleared: key_valid=%b, required 0", bus.key_valid);
    end
    s0 = n_start;
    t0 = n_tx;
    buf_q.push_back(key2);
    wait_drained("mid_key", 100);
    checks++;
    if (bus.key_valid !== 1'b1 || bus.aes_key !== key2) begin
      errors++;
      $display("FAIL mid_new_key: key_valid=%b key=%h, required 1 %h", bus.key_valid, bus.aes_key, key2);
    end
    checks++;
    if (n_start - s0 !== 0 || n_tx - t0 !== 0) begin
      errors++;
      $display("FAIL mid_no_activity: starts=%0d tx=%0d, required 0 and 0", n_start - s0, n_tx - t0);
    end
  endtask

  initial begin
    test_reset();
    test_key_only();
    test_fips_block();
    test_timeout();
    test_slow_tx();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_sequencer.md
# aes_block_sequencer

Controller between the UART receive block buffer, the AES core and the UART transmitter. Pulls 128-bit blocks from the buffer: the first block after reset is latched as the key, and every later block is a plaintext. Each plaintext launches one AES operation, and the ciphertext is then streamed out as 16 bytes. It also drives an optional capture trigger that brackets each encryption for side-channel acquisition.

## Interface
- TIMEOUT, 1024: max cycles to wait for aes_done; range 2..65535.
- READ_HOLD, 4: cycles to wait after buf_read_en before re-examining buf_empty; minimum 2.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low
- buf_empty  in  1  buffer has no readable block
- buf_data  in  128  block at buffer read pointer (show-ahead)
- buf_read_en  out  1  one-cycle pulse; retires current buffer block
- aes_key  out  128  held key
- aes_pt  out  128  held plaintext
- aes_start  out  1  one-cycle pulse; launch encryption
- aes_done  in  1  pulse from AES core; aes_ct valid in the same cycle
- aes_ct  in  128  ciphertext
- tx_data  out  8  byte to transmitter
- tx_start  out  1  one-cycle pulse; send tx_data
- tx_busy  in  1  transmitter busy
- key_valid  out  1  key loaded since reset
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on AES timeout
- trigger  out  1  capture trigger (see Configuration)

## Operation
- All outputs are registered. Reset value of every output and internal register is 0.
- States: IDLE, CAPTURE, RELEASE, START, WAIT_AES, TX_LOAD, TX_WAIT.
- IDLE -> CAPTURE: buf_empty sampled low on two consecutive cycles (debounce, because the buffer's empty flag and data settle one cycle apart).
- CAPTURE: sample buf_data and pulse buf_read_en.
  - If key_valid = 0: buf_data -> aes_key, set key_valid.
  - Otherwise: buf_data -> aes_pt.
  - Then go to RELEASE.
- RELEASE: wait READ_HOLD cycles.
  - If the captured block was the key, return to IDLE.
  - Otherwise go to START.
- START: pulse aes_start for one cycle, clear the timeout counter, go to WAIT_AES.
- WAIT_AES: the counter increments every cycle.
  - If aes_done is sampled high: latch aes_ct into the shift register, byte index = 0, go to TX_LOAD.
  - If the counter reaches TIMEOUT-1 without aes_done: set timeout_err, go to IDLE, transmit nothing.
- TX_LOAD: wait until tx_busy is low. Then drive tx_data = ct[127:120], pulse tx_start, shift ct left by 8, go to TX_WAIT.
- TX_WAIT: ignore tx_busy for the first cycle (transmitter's busy latency). Afterwards, once tx_busy is low:
  - byte index 15 -> IDLE.
  - Otherwise increment the index and go to TX_LOAD.
- Byte order is MSB first: byte 0 = ct[127:120], byte 15 = ct[7:0].
- aes_key and aes_pt stay stable from capture until the next capture. Key changes only through reset.
- aes_done outside WAIT_AES is ignored.
- A buffer block arriving during a busy phase stays in the buffer and is not lost.
- Reset mid-operation aborts immediately:
  - Pending transmit bytes are discarded.
  - key_valid is cleared, so the next block is treated as a key.

## Timing
- buf_empty low at cycles N and N+1 -> buf_read_en high at cycle N+2.
- aes_start for plaintext fires READ_HOLD+1 cycles after buf_read_en.
- aes_done at cycle M -> first tx_start at M+1 if tx_busy is low.
- Consecutive tx_start pulses are separated by at least 3 cycles.
- Throughput is bounded by AES latency plus 16 UART byte times. No overlap between blocks.

## Configuration
- SCA_TRIGGER_EN defined:
  - trigger rises in the cycle aes_start is high.
  - It falls in the cycle after aes_done is sampled, or after a timeout.
  - It is exactly the AES active window.
- SCA_TRIGGER_EN undefined: trigger is constant 0 and no trigger logic is synthesized. The port remains.

## Test plan
- Key + FIPS-197 block:
  - Stimulus: buffer yields key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff; AES model returns 69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after start.
  - Required: aes_key and aes_pt equal the stimulus blocks; exactly one aes_start; tx bytes 69,c4,…,5a in order.
- Key only: one block, then idle.
  - Required: key_valid = 1; no aes_start; no tx_start; busy returns to 0 after READ_HOLD+1 cycles.
- Timeout with TIMEOUT=16 and aes_done never asserted:
  - Required: timeout_err = 1 at start+16; no tx_start; the next block still gets an aes_start.
- Slow transmitter holding tx_busy high 50 cycles per byte:
  - Required: 16 tx_start pulses, each issued only with tx_busy low; second plaintext not read until byte 15 finishes.
- Reset asserted low after 5 bytes transmitted:
  - Required: all outputs 0 within the reset cycle; after release, the next block loads as key (key_valid 0 -> 1).
- With SCA_TRIGGER_EN:
  - Required: trigger high for exactly 11 cycles with a 10-cycle AES model.
  - Without the macro, trigger stays 0 throughout.
